// File: rtl/rv32i_types.sv
// Shared RV32I type definitions used by the store path.
//   store_funct3_t : store funct3 encodings (sb/sh/sw/sd)
//   sb_size_t      : store size code carried in funct3[1:0]
//   size_bytes()   : number of bytes touched by a given size code
// Store-buffer entries depend on the width parameters of the buffer instance,
// so the entry record itself is declared inside the buffer module.
package rv32i_types;

  typedef enum logic [2:0] {
    STORE_SB = 3'b000,
    STORE_SH = 3'b001,
    STORE_SW = 3'b010,
    STORE_SD = 3'b011
  } store_funct3_t;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } sb_size_t;

  function automatic logic [3:0] size_bytes(sb_size_t s);
    logic [3:0] n;
    unique case (s)
      SZ_BYTE: n = 4'd1;
      SZ_HALF: n = 4'd2;
      SZ_WORD: n = 4'd4;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dcache_store_buffer_if.sv
// Bundle of the store-request, load-forward-check and dcache-write signals of
// the store buffer.
//   slave  : store buffer side (accepts stores, drives mem_* writes)
//   master : pipeline/dcache side (issues stores, answers mem_resp)
interface dcache_store_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int NBYTES = DATA_WIDTH / 8;

  logic                  st_valid;
  logic                  st_ready;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [2:0]            st_funct3;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic                  st_err;
  logic [ADDR_WIDTH-1:0] fwd_addr;
  logic                  fwd_hit;
  logic                  flush;
  logic                  empty;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NBYTES-1:0]     mem_byte_enable;
  logic                  mem_resp;

  modport slave (
    input  st_valid, st_addr, st_funct3, st_wdata, fwd_addr, flush, mem_resp,
    output st_ready, st_err, fwd_hit, empty,
           mem_write, mem_address, mem_wdata, mem_byte_enable
  );

  modport master (
    output st_valid, st_addr, st_funct3, st_wdata, fwd_addr, flush, mem_resp,
    input  st_ready, st_err, fwd_hit, empty,
           mem_write, mem_address, mem_wdata, mem_byte_enable
  );

endinterface

// File: rtl/dcache_store_lane_align.sv
// Combinational store lane aligner.
// Turns an LSB-justified store (funct3, byte offset, data) into a word-wide
// lane image: the low 8*bytes bits of data_in replicated across the word, a
// byte mask covering the addressed bytes, and an error flag for illegal size
// codes or misaligned offsets (mask forced to zero on error).
//   funct3   in  store funct3, [1:0] is the size code, [2] must be 0
//   offset   in  byte offset within the dcache word
//   data_in  in  LSB-justified store data
//   data_out out replicated lane data
//   mask_out out byte mask
//   err      out illegal or misaligned store
module dcache_store_lane_align
  import rv32i_types::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]                      funct3,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] offset,
  input  logic [DATA_WIDTH-1:0]           data_in,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic [DATA_WIDTH/8-1:0]         mask_out,
  output logic                            err
);
  localparam int NBYTES = DATA_WIDTH / 8;

  sb_size_t   size;
  logic [3:0] nbytes_sel;
  logic [3:0] off_ext;
  logic [3:0] span_end;
  logic       illegal;
  logic       misaligned;

  assign size       = sb_size_t'(funct3[1:0]);
  assign nbytes_sel = size_bytes(size);
  assign off_ext    = 4'(offset);
  assign span_end   = off_ext + nbytes_sel;
  assign illegal    = funct3[2] || (size == SZ_DWORD && DATA_WIDTH == 32);
  // Sizes are powers of two, so "offset mod bytes" is a low-bit mask.
  assign misaligned = (off_ext & (nbytes_sel - 4'd1)) != 4'd0;
  assign err        = illegal || misaligned;

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    logic [7:0] lane_byte;

    // Byte gi of the replicated image is source byte (gi mod bytes).
    always_comb begin
      lane_byte = data_in[7:0];
      unique case (size)
        SZ_BYTE: lane_byte = data_in[7:0];
        SZ_HALF: lane_byte = data_in[8*(gi%2) +: 8];
        SZ_WORD: lane_byte = data_in[8*(gi%4) +: 8];
        default: lane_byte = data_in[8*(gi%8) +: 8];
      endcase
    end

    assign data_out[8*gi +: 8] = lane_byte;
    assign mask_out[gi] = !err && (4'(gi) >= off_ext) && (4'(gi) < span_end);
  end

endmodule

// File: rtl/dcache_store_buffer.sv
// Store buffer between the MEM stage and the data cache.
// Stores are lane-aligned, merged into the youngest entry when they hit the
// same word, otherwise queued in a DEPTH-entry FIFO. The head entry is drained
// to the dcache with a mem_write/mem_resp handshake, one write at a time with
// an idle cycle between writes. fwd_hit flags loads whose word has a pending
// store.
//   clk    in  clock, rising edge
//   rst_n  in  synchronous active-low reset
//   sb     slave side of dcache_store_buffer_if (store request, st_err,
//          fwd_addr/fwd_hit, flush/empty, mem_* dcache write port)
module dcache_store_buffer
  import rv32i_types::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input logic              clk,
  input logic              rst_n,
  dcache_store_buffer_if.slave sb
);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(NBYTES);
  localparam int WA_W   = ADDR_WIDTH - OFF_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic                  valid;
    logic [WA_W-1:0]       waddr;
    logic [DATA_WIDTH-1:0] data;
    logic [NBYTES-1:0]     mask;
  } sb_entry_t;

  typedef enum logic {S_IDLE, S_WRITE} drain_state_t;

  sb_entry_t             entry_reg [DEPTH];
  logic [PTR_W-1:0]      head_ptr_reg;
  logic [PTR_W-1:0]      tail_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  drain_state_t          state_reg;
  logic                  mem_write_reg;
  logic [ADDR_WIDTH-1:0] mem_address_reg;
  logic [DATA_WIDTH-1:0] mem_wdata_reg;
  logic [NBYTES-1:0]     mem_byte_enable_reg;
  logic                  st_err_reg;

  logic [DATA_WIDTH-1:0] st_lane_data;
  logic [NBYTES-1:0]     st_lane_mask;
  logic                  st_lane_err;
  logic [WA_W-1:0]       st_waddr;
  logic [PTR_W-1:0]      last_ptr;
  logic                  merge_ok;
  logic                  accept;
  logic                  do_merge;
  logic                  do_alloc;
  logic                  pop;
  logic                  merge_into_head;
  logic [DATA_WIDTH-1:0] merged_data;
  logic [NBYTES-1:0]     merged_mask;
  logic [DEPTH-1:0]      hit_vec;
  logic                  unused_fwd_bits;

  dcache_store_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .funct3   (sb.st_funct3),
    .offset   (sb.st_addr[OFF_W-1:0]),
    .data_in  (sb.st_wdata),
    .data_out (st_lane_data),
    .mask_out (st_lane_mask),
    .err      (st_lane_err)
  );

  assign st_waddr = sb.st_addr[ADDR_WIDTH-1:OFF_W];
  assign last_ptr = tail_ptr_reg - PTR_W'(1);

  // Merging into the head while it is being written would change data the
  // dcache is already consuming, so that case allocates a fresh entry.
  assign merge_ok = (count_reg != '0)
                 && (entry_reg[last_ptr].waddr == st_waddr)
                 && !(state_reg == S_WRITE && last_ptr == head_ptr_reg);

  assign sb.st_ready = !sb.flush && ((count_reg < CNT_W'(DEPTH)) || merge_ok);

  assign accept   = sb.st_valid && sb.st_ready;
  assign do_merge = accept && !st_lane_err && merge_ok;
  assign do_alloc = accept && !st_lane_err && !merge_ok;
  assign pop      = (state_reg == S_WRITE) && sb.mem_resp;

  // A merge into the head on the same edge the drain launches it must be
  // captured on mem_*, otherwise those bytes would be lost at pop.
  assign merge_into_head = do_merge && (last_ptr == head_ptr_reg);

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_merge
    assign merged_data[8*gi +: 8] = st_lane_mask[gi] ? st_lane_data[8*gi +: 8]
                                                     : entry_reg[last_ptr].data[8*gi +: 8];
  end
  assign merged_mask = entry_reg[last_ptr].mask | st_lane_mask;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd
    assign hit_vec[gi] = entry_reg[gi].valid
                      && (entry_reg[gi].waddr == sb.fwd_addr[ADDR_WIDTH-1:OFF_W]);
  end
  assign sb.fwd_hit = |hit_vec;

  // Only the word address of a load matters for the hazard check.
  assign unused_fwd_bits = ^sb.fwd_addr[OFF_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_reg[i] <= '0;
      end
      head_ptr_reg        <= '0;
      tail_ptr_reg        <= '0;
      count_reg           <= '0;
      state_reg           <= S_IDLE;
      mem_write_reg       <= 1'b0;
      mem_address_reg     <= '0;
      mem_wdata_reg       <= '0;
      mem_byte_enable_reg <= '0;
      st_err_reg          <= 1'b0;
    end else begin
      st_err_reg <= accept && st_lane_err;
      count_reg  <= count_reg + CNT_W'(do_alloc) - CNT_W'(pop);

      if (do_merge) begin
        entry_reg[last_ptr].data <= merged_data;
        entry_reg[last_ptr].mask <= merged_mask;
      end

      if (pop) begin
        entry_reg[head_ptr_reg].valid <= 1'b0;
        head_ptr_reg <= head_ptr_reg + PTR_W'(1);
      end

      // Allocation never targets the popped slot: it needs count < DEPTH.
      if (do_alloc) begin
        entry_reg[tail_ptr_reg] <= '{valid: 1'b1, waddr: st_waddr,
                                     data: st_lane_data, mask: st_lane_mask};
        tail_ptr_reg <= tail_ptr_reg + PTR_W'(1);
      end

      unique case (state_reg)
        S_IDLE: begin
          if (count_reg != '0) begin
            state_reg       <= S_WRITE;
            mem_write_reg   <= 1'b1;
            mem_address_reg <= {entry_reg[head_ptr_reg].waddr, {OFF_W{1'b0}}};
            if (merge_into_head) begin
              mem_wdata_reg       <= merged_data;
              mem_byte_enable_reg <= merged_mask;
            end else begin
              mem_wdata_reg       <= entry_reg[head_ptr_reg].data;
              mem_byte_enable_reg <= entry_reg[head_ptr_reg].mask;
            end
          end
        end
        default: begin
          if (sb.mem_resp) begin
            state_reg     <= S_IDLE;
            mem_write_reg <= 1'b0;
          end
        end
      endcase
    end
  end

  assign sb.empty           = (count_reg == '0) && (state_reg == S_IDLE);
  assign sb.st_err          = st_err_reg;
  assign sb.mem_write       = mem_write_reg;
  assign sb.mem_address     = mem_address_reg;
  assign sb.mem_wdata       = mem_wdata_reg;
  assign sb.mem_byte_enable = mem_byte_enable_reg;

endmodule

// File: tb/tb_dcache_store_buffer.sv
// Testbench for dcache_store_buffer: one 32-bit and one 64-bit instance,
// exercised one after the other with directed sequences and random traffic,
// every cycle compared against a queue-based reference model.
module tb_dcache_store_buffer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n32;
  logic rst_n64;

  dcache_store_buffer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus32 ();
  dcache_store_buffer_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus64 ();

  dcache_store_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH)) dut32 (
    .clk   (clk),
    .rst_n (rst_n32),
    .sb    (bus32)
  );

  dcache_store_buffer #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(DEPTH)) dut64 (
    .clk   (clk),
    .rst_n (rst_n64),
    .sb    (bus64)
  );

  // Reference model: pending stores as a queue of whole words, plus the
  // word currently presented to the dcache.
  typedef struct {
    logic [31:0] waddr;
    logic [63:0] data;
    logic [7:0]  mask;
  } ment_t;

  ment_t       q[$];
  bit          m_busy;
  bit          m_err;
  logic [31:0] m_addr;
  logic [63:0] m_data;
  logic [7:0]  m_mask;

  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_busy = 1'b0;
    m_err  = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_mask = '0;
  endfunction

  // Lane image from the store rules: mask of 'bytes' ones shifted to the
  // offset, data = low 8*bytes bits repeated to fill the word.
  function automatic void lane(input int w, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [63:0] wd, output bit err,
                               output logic [63:0] data, output logic [7:0] mask);
    int nb;
    int off;
    int bytes;
    logic [63:0] pat;
    nb    = w / 8;
    off   = int'(addr % nb);
    bytes = 1 << f3[1:0];
    err   = f3[2] || (bytes == 8 && w == 32) || (off % bytes != 0);
    mask  = 8'(((1 << bytes) - 1) << off);
    if (bytes == 8) pat = wd;
    else pat = wd & ((64'd1 << (8 * bytes)) - 64'd1);
    data = '0;
    for (int k = 0; k < nb / bytes; k++) begin
      data = data | (pat << (8 * bytes * k));
    end
  endfunction

  task automatic clear_bus(input int w);
    if (w == 32) begin
      bus32.st_valid = 0; bus32.st_addr = '0; bus32.st_funct3 = '0; bus32.st_wdata = '0;
      bus32.fwd_addr = '0; bus32.flush = 0; bus32.mem_resp = 0;
    end else begin
      bus64.st_valid = 0; bus64.st_addr = '0; bus64.st_funct3 = '0; bus64.st_wdata = '0;
      bus64.fwd_addr = '0; bus64.flush = 0; bus64.mem_resp = 0;
    end
  endtask

  task automatic do_reset(input int w);
    @(negedge clk);
    clear_bus(w);
    if (w == 32) rst_n32 = 1'b0; else rst_n64 = 1'b0;
    @(negedge clk);
    if (w == 32) rst_n32 = 1'b1; else rst_n64 = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance it.
  task automatic step(input int w, input bit v, input logic [31:0] addr, input logic [2:0] f3,
                      input logic [63:0] wd_in, input logic [31:0] faddr,
                      input bit fl, input bit resp);
    int nb;
    logic [63:0] wd;
    logic [31:0] wa;
    logic [31:0] fwa;
    bit merge_ok, exp_ready, exp_hit, exp_empty, acc, lerr, start, pop;
    logic [63:0] ld, bm;
    logic [7:0] lm;
    bit g_ready, g_err, g_hit, g_empty, g_mw;
    logic [31:0] g_ma;
    logic [63:0] g_md;
    logic [7:0] g_mbe;
    ment_t e;
    string pfx;

    nb  = w / 8;
    wd  = wd_in;
    if (w == 32) wd[63:32] = '0;
    wa  = addr / nb;
    fwa = faddr / nb;
    pfx = $sformatf("w%0d", w);

    @(negedge clk);
    if (w == 32) begin
      bus32.st_valid = v; bus32.st_addr = addr; bus32.st_funct3 = f3;
      bus32.st_wdata = wd[31:0]; bus32.fwd_addr = faddr; bus32.flush = fl;
      bus32.mem_resp = resp;
    end else begin
      bus64.st_valid = v; bus64.st_addr = addr; bus64.st_funct3 = f3;
      bus64.st_wdata = wd; bus64.fwd_addr = faddr; bus64.flush = fl;
      bus64.mem_resp = resp;
    end
    #1;
    if (w == 32) begin
      g_ready = bus32.st_ready; g_err = bus32.st_err; g_hit = bus32.fwd_hit;
      g_empty = bus32.empty; g_mw = bus32.mem_write; g_ma = bus32.mem_address;
      g_md = {32'h0, bus32.mem_wdata}; g_mbe = {4'h0, bus32.mem_byte_enable};
    end else begin
      g_ready = bus64.st_ready; g_err = bus64.st_err; g_hit = bus64.fwd_hit;
      g_empty = bus64.empty; g_mw = bus64.mem_write; g_ma = bus64.mem_address;
      g_md = bus64.mem_wdata; g_mbe = bus64.mem_byte_enable;
    end

    merge_ok  = q.size() > 0 && q[q.size()-1].waddr == wa && !(m_busy && q.size() == 1);
    exp_ready = !fl && (q.size() < DEPTH || merge_ok);
    exp_hit   = 1'b0;
    foreach (q[i]) if (q[i].waddr == fwa) exp_hit = 1'b1;
    exp_empty = q.size() == 0 && !m_busy;

    check_eq({pfx, " st_ready"}, 64'(g_ready), 64'(exp_ready));
    check_eq({pfx, " st_err"}, 64'(g_err), 64'(m_err));
    check_eq({pfx, " fwd_hit"}, 64'(g_hit), 64'(exp_hit));
    check_eq({pfx, " empty"}, 64'(g_empty), 64'(exp_empty));
    check_eq({pfx, " mem_write"}, 64'(g_mw), 64'(m_busy));
    check_eq({pfx, " mem_address"}, 64'(g_ma), 64'(m_addr));
    check_eq({pfx, " mem_wdata"}, g_md, m_data);
    check_eq({pfx, " mem_byte_enable"}, 64'(g_mbe), 64'(m_mask));

    acc = v && exp_ready;
    lane(w, f3, addr, wd, lerr, ld, lm);
    start = !m_busy && q.size() > 0;
    pop   = m_busy && resp;

    if (acc && !lerr && merge_ok) begin
      bm = '0;
      for (int b = 0; b < 8; b++) if (lm[b]) bm[8*b +: 8] = 8'hFF;
      e = q[q.size()-1];
      e.data = (e.data & ~bm) | (ld & bm);
      e.mask = e.mask | lm;
      q[q.size()-1] = e;
    end
    if (start) begin
      m_addr = q[0].waddr * nb;
      m_data = q[0].data;
      m_mask = q[0].mask;
    end
    if (pop) void'(q.pop_front());
    if (acc && !lerr && !merge_ok) begin
      e.waddr = wa; e.data = ld; e.mask = lm;
      q.push_back(e);
    end
    m_err = acc && lerr;
    if (start) m_busy = 1'b1;
    else if (pop) m_busy = 1'b0;
  endtask

  task automatic idle(input int w, input logic [31:0] faddr, input bit resp);
    step(w, 0, '0, '0, '0, faddr, 0, resp);
  endtask

  task automatic drain(input int w, input logic [31:0] faddr);
    repeat (12) idle(w, faddr, 1);
  endtask

  task automatic run_phase(input int w);
    int nb;
    bit v, fl, resp;
    logic [31:0] addr, faddr;
    logic [2:0] f3;
    int r, off, bytes;
    nb = w / 8;

    do_reset(w);
    idle(w, 32'h0, 0);

    // single word, response three cycles into the write
    step(w, 1, 32'h100, 3'b010, 64'hDEADBEEF, 32'h100, 0, 0);
    repeat (4) idle(w, 32'h100, 0);
    idle(w, 32'h100, 1);
    repeat (2) idle(w, 32'h100, 0);

    // two byte stores merge behind a stalled head on another word
    step(w, 1, 32'h400, 3'b010, 64'h11223344, 32'h200, 0, 0);
    repeat (2) idle(w, 32'h200, 0);
    step(w, 1, 32'h203, 3'b000, 64'hAA, 32'h200, 0, 0);
    step(w, 1, 32'h201, 3'b000, 64'hBB, 32'h200, 0, 0);
    repeat (2) idle(w, 32'h200, 0);
    drain(w, 32'h200);

    // misaligned and illegal stores
    step(w, 1, 32'h101, 3'b001, 64'h1234, 32'h100, 0, 0);
    step(w, 1, 32'h102, 3'b010, 64'h5678, 32'h100, 0, 0);
    step(w, 1, 32'h100, 3'b100, 64'h9ABC, 32'h100, 0, 0);
    repeat (2) idle(w, 32'h100, 0);

    // fill to DEPTH, fifth store waits for a pop
    for (int i = 0; i < 4; i++) step(w, 1, 32'h500 + i * nb, 3'b010, 64'(i + 1), 32'h500, 0, 0);
    repeat (2) step(w, 1, 32'h580, 3'b010, 64'h55, 32'h500, 0, 0);
    step(w, 1, 32'h580, 3'b010, 64'h55, 32'h500, 0, 1);
    step(w, 1, 32'h580, 3'b010, 64'h55, 32'h580, 0, 0);
    drain(w, 32'h580);

    // same word as the head already in WRITE
    step(w, 1, 32'h300, 3'b010, 64'hA5A5A5A5, 32'h302, 0, 0);
    repeat (2) idle(w, 32'h302, 0);
    step(w, 1, 32'h300, 3'b010, 64'h5A5A5A5A, 32'h302, 0, 0);
    repeat (2) idle(w, 32'h302, 0);
    drain(w, 32'h302);

    // doubleword and upper-word stores, then flush while draining
    step(w, 1, 32'h8, 3'b011, 64'h0123456789ABCDEF, 32'h8, 0, 0);
    step(w, 1, 32'h4, 3'b010, 64'hCAFEF00D, 32'h4, 0, 0);
    repeat (3) step(w, 1, 32'h700, 3'b010, 64'h77, 32'h4, 1, 0);
    repeat (10) step(w, 1, 32'h700, 3'b010, 64'h77, 32'h4, 1, 1);
    idle(w, 32'h4, 0);

    // reset while a write is outstanding
    step(w, 1, 32'h600, 3'b010, 64'h66, 32'h600, 0, 0);
    repeat (2) idle(w, 32'h600, 0);
    do_reset(w);
    repeat (2) idle(w, 32'h600, 0);

    // random traffic on a small set of words
    for (int n = 0; n < 400; n++) begin
      v = $urandom_range(0, 99) < 60;
      r = $urandom_range(0, 19);
      if (r == 0) f3 = 3'b100 | 3'($urandom_range(0, 3));
      else if (r < 5) f3 = 3'b000;
      else if (r < 9) f3 = 3'b001;
      else if (r < 15) f3 = 3'b010;
      else f3 = 3'b011;
      bytes = 1 << f3[1:0];
      off = $urandom_range(0, nb - 1);
      if ($urandom_range(0, 3) != 0 && bytes <= nb) off = off - (off % bytes);
      addr  = 32'h300 + 32'($urandom_range(0, 3) * nb + off);
      faddr = 32'h300 + 32'($urandom_range(0, 4) * nb);
      fl    = $urandom_range(0, 99) < 8;
      resp  = $urandom_range(0, 99) < 40;
      step(w, v, addr, f3, {$urandom, $urandom}, faddr, fl, resp);
    end
    drain(w, 32'h300);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n32  = 1'b0;
    rst_n64  = 1'b0;
    clear_bus(32);
    clear_bus(64);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n32 = 1'b1;
    rst_n64 = 1'b1;
    run_phase(32);
    run_phase(64);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
